// File: rtl/ring_sequence_monitor.sv
// Ring sequence monitor: checks that a one-hot ring counter rotates correctly,
// locks onto it, counts revolutions and flags faults while locked.
module ring_sequence_monitor #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned REV_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [WIDTH-1:0]         phase,
  input  logic                     clr_count,
  output logic                     locked,
  output logic                     err,
  output logic                     err_sticky,
  output logic                     rev_tick,
  output logic [REV_W-1:0]         rev_count,
  output logic [$clog2(WIDTH)-1:0] phase_idx
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] TOP_PHASE = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACQUIRE = 3'd1,
    S_TRACK   = 3'd2,
    S_LOCKED  = 3'd3,
    S_FAULT   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [CNT_W-1:0]   good_q, good_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic               sticky_q, sticky_d;
  logic               tick_q, tick_d;
  logic [REV_W-1:0]   rev_q, rev_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [WIDTH-1:0]   exp_phase;
  logic               is_one_hot;
  logic               step_ok;
  logic [IDX_W-1:0]   idx_c;
  logic [CNT_W-1:0]   good_inc;

  // Sample classification: one-hot check, expected rotation and bit index
  always_comb begin
    exp_phase  = {prev_q[0], prev_q[WIDTH-1:1]};
    is_one_hot = (phase != '0) && ((phase & (phase - WIDTH'(1))) == '0);
    step_ok    = is_one_hot && (phase == exp_phase);
    good_inc   = good_q + CNT_W'(1);
    idx_c      = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (phase[i]) idx_c = IDX_W'(i);
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    prev_d   = phase;
    good_d   = good_q;
    err_d    = 1'b0;
    tick_d   = 1'b0;
    sticky_d = sticky_q;
    rev_d    = rev_q;
    idx_d    = is_one_hot ? idx_c : idx_q;

    if (!en) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:    state_d = S_ACQUIRE;
        S_ACQUIRE: begin
          if (is_one_hot) begin
            state_d = S_TRACK;
            good_d  = '0;
          end
        end
        S_TRACK: begin
          if (step_ok) begin
            good_d = good_inc;
            if (good_inc == CNT_W'(LOCK_COUNT)) state_d = S_LOCKED;
          end else begin
            state_d = S_ACQUIRE;
          end
        end
        S_LOCKED: begin
          if (step_ok) begin
            if (phase == TOP_PHASE) begin
              tick_d = 1'b1;
              rev_d  = rev_q + REV_W'(1);
            end
          end else begin
            err_d    = 1'b1;
            sticky_d = 1'b1;
            state_d  = S_FAULT;
          end
        end
        S_FAULT:   state_d = S_ACQUIRE;
        default:   state_d = S_IDLE;
      endcase
    end

    // Clear overrides a coincident increment or fault
    if (clr_count) begin
      rev_d    = '0;
      sticky_d = 1'b0;
    end

    locked_d = (state_d == S_LOCKED);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      prev_q   <= '0;
      good_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      tick_q   <= 1'b0;
      rev_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      good_q   <= good_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      tick_q   <= tick_d;
      rev_q    <= rev_d;
      idx_q    <= idx_d;
    end
  end

  assign locked     = locked_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign rev_tick   = tick_q;
  assign rev_count  = rev_q;
  assign phase_idx  = idx_q;

endmodule
